// File: rtl/irq_frontend_pkg.sv
// Shared types, constants and helpers for the interrupt front end.
// Helpers take fixed maximum widths; callers extend and truncate to their own.
package irq_frontend_pkg;

    localparam int unsigned IRQ_W_DFLT = 4;
    localparam int unsigned NIRQ       = 2 ** IRQ_W_DFLT;
    localparam int unsigned VEC_OFF_W  = 7;
    localparam int unsigned IRQ_W_MAX  = 8;
    localparam int unsigned NIRQ_MAX   = 2 ** IRQ_W_MAX;

    typedef enum logic [1:0] {SeqRst, SeqArm, SeqRel, SeqRun} seq_state_e;
    typedef enum logic {OutIdle, OutPresent} out_state_e;

    function automatic logic [63:0] build_ip(input logic [31:0] vec_base,
                                             input logic [IRQ_W_MAX-1:0] num,
                                             input int unsigned irq_w);
        return (64'(vec_base) << (irq_w + VEC_OFF_W)) | (64'(num) << VEC_OFF_W);
    endfunction

    function automatic logic [IRQ_W_MAX-1:0] lowest_set(input logic [NIRQ_MAX-1:0] v);
        logic [IRQ_W_MAX-1:0] r;
        r = '0;
        for (int i = NIRQ_MAX - 1; i >= 0; i--) begin
            if (v[i]) r = IRQ_W_MAX'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_fifo.sv
// Small synchronous FIFO; a push into a full FIFO succeeds only when paired with a pop.
module irq_fifo #(
    parameter int unsigned Width = 4,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW + 1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    always_comb begin
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = wdata_i;
        // Pointers wrap naturally because Depth is a power of two.
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/irq_frontend_seq.sv
// Staged reset release plus a deduplicated, handshaked interrupt queue for one tile.
// MODE 0 delivers in arrival order through a FIFO; MODE 1 delivers lowest pending number first.
import irq_frontend_pkg::*;

module irq_frontend_seq #(
    parameter int unsigned IRQ_W      = IRQ_W_DFLT,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IP_W       = 42,
    parameter int unsigned VEC_BASE   = 1,
    parameter int unsigned RST_STAGES = 5,
    parameter int unsigned MODE       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    irqload,
    input  logic [IRQ_W-1:0]        irqnum,
    input  logic [(2**IRQ_W)-1:0]   irq_mask,
    output logic                    irq_valid,
    input  logic                    irq_ready,
    output logic [IRQ_W-1:0]        irq_num,
    output logic [IP_W-1:0]         irq_IP,
    output logic [(2**IRQ_W)-1:0]   irq_pend,
    output logic                    irq_ovf,
    input  logic                    ovf_clr,
    output logic [RST_STAGES-1:0]   rst_stage,
    output logic                    seq_done
);

    localparam int unsigned NumLines = 2 ** IRQ_W;
    localparam bit          UseFifo  = (MODE == 0);

    seq_state_e              seq_q, seq_d;
    logic [RST_STAGES-1:0]   stage_q, stage_d;
    logic                    done_q, done_d;
    out_state_e              out_q, out_d;
    logic                    valid_q, valid_d;
    logic [IRQ_W-1:0]        num_q, num_d;
    logic [IP_W-1:0]         ip_q, ip_d;
    logic [NumLines-1:0]     pend_q, pend_d;
    logic                    ovf_q, ovf_d;

    logic                    accept, load_ok, new_req, overflow, has_pending;
    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [IRQ_W-1:0]        fifo_head, sel_num;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    generate
        if (MODE == 0) begin : g_fifo
            irq_fifo #(
                .Width (IRQ_W),
                .Depth (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .push_i  (fifo_push),
                .pop_i   (fifo_pop),
                .wdata_i (irqnum),
                .rdata_o (fifo_head),
                .full_o  (fifo_full),
                .empty_o (fifo_empty),
                .count_o (fifo_count)
            );
        end else begin : g_no_fifo
            assign fifo_head  = '0;
            assign fifo_full  = 1'b0;
            assign fifo_empty = 1'b1;
            assign fifo_count = '0;
        end
    endgenerate

    // Reset release: shift zeros in from bit 0, one stage per clock.
    always_comb begin
        seq_d   = seq_q;
        stage_d = stage_q;
        done_d  = done_q;
        case (seq_q)
            SeqRst: seq_d = SeqArm;
            SeqArm, SeqRel: begin
                stage_d = stage_q << 1;
                done_d  = (stage_d == '0);
                seq_d   = done_d ? SeqRun : SeqRel;
            end
            default: ;
        endcase
    end

    always_comb begin
        accept   = valid_q & irq_ready;
        load_ok  = done_q & irqload & ~irq_mask[irqnum];
        // A line being accepted this cycle counts as free, so a same-number strobe re-arms it.
        new_req  = load_ok & (~pend_q[irqnum] | (accept & (num_q == irqnum)));
        fifo_pop = UseFifo & accept & (fifo_count != '0);
        fifo_push = UseFifo & new_req & (~fifo_full | fifo_pop);
        overflow = UseFifo & new_req & fifo_full & ~fifo_pop;

        pend_d = pend_q;
        if (accept) pend_d[num_q] = 1'b0;
        if (UseFifo ? fifo_push : new_req) pend_d[irqnum] = 1'b1;

        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (overflow) ovf_d = 1'b1;

        has_pending = UseFifo ? ~fifo_empty : (pend_q != '0);
        sel_num     = UseFifo ? fifo_head : IRQ_W'(lowest_set(NIRQ_MAX'(pend_q)));

        out_d   = out_q;
        valid_d = valid_q;
        num_d   = num_q;
        ip_d    = ip_q;
        case (out_q)
            OutIdle: begin
                if (has_pending) begin
                    out_d   = OutPresent;
                    valid_d = 1'b1;
                    num_d   = sel_num;
                    ip_d    = IP_W'(build_ip(VEC_BASE, IRQ_W_MAX'(sel_num), IRQ_W));
                end
            end
            OutPresent: begin
                if (irq_ready) begin
                    out_d   = OutIdle;
                    valid_d = 1'b0;
                end
            end
            default: out_d = OutIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q   <= SeqRst;
            stage_q <= '1;
            done_q  <= 1'b0;
            out_q   <= OutIdle;
            valid_q <= 1'b0;
            num_q   <= '0;
            ip_q    <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            num_q   <= num_d;
            ip_q    <= ip_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rst_stage = stage_q;
    assign seq_done  = done_q;
    assign irq_valid = valid_q;
    assign irq_num   = num_q;
    assign irq_IP    = ip_q;
    assign irq_pend  = pend_q;
    assign irq_ovf   = ovf_q;

endmodule

// File: tb/tb_irq_frontend_seq.sv
// Bench for irq_frontend_seq: one FIFO-mode and one priority-mode instance on shared inputs.
module tb_irq_frontend_seq;

    localparam int unsigned IRQ_W = 4;
    localparam int unsigned NIRQ = 16;
    localparam int unsigned IP_W = 42;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned RST_STAGES = 5;
    localparam int unsigned VEC_BASE = 1;

    logic clk = 1'b0, rst = 1'b1, irqload = 1'b0, irq_ready = 1'b0, ovf_clr = 1'b0;
    logic [IRQ_W-1:0] irqnum = '0;
    logic [NIRQ-1:0] irq_mask = '0;

    logic v0, v1, ovf0, ovf1, done0, done1;
    logic [IRQ_W-1:0] n0, n1;
    logic [IP_W-1:0] ip0, ip1;
    logic [NIRQ-1:0] pend0, pend1;
    logic [RST_STAGES-1:0] stg0, stg1;

    always #5 clk = ~clk;

    irq_frontend_seq #(.IRQ_W(IRQ_W), .FIFO_DEPTH(FIFO_DEPTH), .IP_W(IP_W), .VEC_BASE(VEC_BASE),
                       .RST_STAGES(RST_STAGES), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .irqload(irqload), .irqnum(irqnum), .irq_mask(irq_mask),
        .irq_valid(v0), .irq_ready(irq_ready), .irq_num(n0), .irq_IP(ip0), .irq_pend(pend0),
        .irq_ovf(ovf0), .ovf_clr(ovf_clr), .rst_stage(stg0), .seq_done(done0));

    irq_frontend_seq #(.IRQ_W(IRQ_W), .FIFO_DEPTH(FIFO_DEPTH), .IP_W(IP_W), .VEC_BASE(VEC_BASE),
                       .RST_STAGES(RST_STAGES), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .irqload(irqload), .irqnum(irqnum), .irq_mask(irq_mask),
        .irq_valid(v1), .irq_ready(irq_ready), .irq_num(n1), .irq_IP(ip1), .irq_pend(pend1),
        .irq_ovf(ovf1), .ovf_clr(ovf_clr), .rst_stage(stg1), .seq_done(done1));

    int checks = 0;
    int errors = 0;
    int sel = 0;
    int unsigned cyc = 0;
    int exp_q[$];
    int obs_num[$];
    logic [IP_W-1:0] obs_ip[$];
    int unsigned obs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every vector that will be accepted at the coming edge.
    always @(negedge clk) begin
        if (!rst && irq_ready && (sel == 0 ? v0 : v1)) begin
            obs_num.push_back(sel == 0 ? int'(n0) : int'(n1));
            obs_ip.push_back(sel == 0 ? ip0 : ip1);
            obs_cyc.push_back(cyc);
        end
    end

    function automatic logic [IP_W-1:0] exp_ip(input int n);
        logic [IP_W-1:0] r;
        r = (IP_W'(VEC_BASE) << (IRQ_W + 7)) | (IP_W'(n) << 7);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n);
        irqload = 1'b1;
        irqnum = IRQ_W'(n);
        tick();
        irqload = 1'b0;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        irq_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (obs_num.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        irq_ready = 1'b0;
    endtask

    task automatic do_reset();
        bit ok;
        rst = 1'b1;
        irqload = 1'b0;
        irq_ready = 1'b0;
        ovf_clr = 1'b0;
        irq_mask = '0;
        tick();
        tick();
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done0 && done1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_release_timeout done0=%0b done1=%0b required 1", done0, done1);
        end
        exp_q.delete();
        obs_num.delete();
        obs_ip.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        logic [RST_STAGES-1:0] tab [6];
        tab = '{5'h1F, 5'h1E, 5'h1C, 5'h18, 5'h10, 5'h00};
        rst = 1'b1;
        tick();
        checks++;
        if ({stg0, done0, v0, n0, ip0, pend0, ovf0} !== {5'h1F, 1'b0, 1'b0, 4'h0, 42'h0, 16'h0, 1'b0})
        begin
            errors++;
            $display("FAIL reset_values stg=%h done=%b v=%b num=%h ip=%h pend=%h ovf=%b",
                     stg0, done0, v0, n0, ip0, pend0, ovf0);
        end
        rst = 1'b0;
        irqload = 1'b1;
        irqnum = 4'd4;
        for (int i = 0; i < 6; i++) begin
            tick();
            irqload = 1'b0;
            checks++;
            if (stg0 !== tab[i] || done0 !== (i == 5)) begin
                errors++;
                $display("FAIL release_edge%0d stage=%h done=%b required stage=%h done=%b",
                         i + 1, stg0, done0, tab[i], (i == 5));
            end
        end
        tick();
        checks++;
        if (pend0 !== 16'h0 || v0 !== 1'b0) begin
            errors++;
            $display("FAIL early_load_ignored pend=%h valid=%b required 0000/0", pend0, v0);
        end
    endtask

    task automatic test_fifo_order();
        bit ok;
        int n, on;
        int unsigned prev;
        do_reset();
        sel = 0;
        load(3);
        checks++;
        if (v0 !== 1'b0) begin
            errors++;
            $display("FAIL latency_early valid=%b required 0", v0);
        end
        load(9);
        checks++;
        if (v0 !== 1'b1) begin
            errors++;
            $display("FAIL latency_one valid=%b required 1", v0);
        end
        load(3);
        exp_q.push_back(3);
        exp_q.push_back(9);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (pend0 !== 16'h0208 || n0 !== 4'd3 || ip0 !== 42'h980) begin
            errors++;
            $display("FAIL dedup_hold pend=%h num=%0d ip=%h required 0208/3/980", pend0, n0, ip0);
        end
        wait_obs(2, ok);
        tick();
        tick();
        checks++;
        if (!ok || obs_num.size() != 2 || pend0 !== 16'h0) begin
            errors++;
            $display("FAIL fifo_drain got=%0d pend=%h required 2 vectors, pend 0000",
                     obs_num.size(), pend0);
        end
        prev = 0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            n = exp_q.pop_front();
            on = (obs_num.size() > 0) ? obs_num.pop_front() : -1;
            checks++;
            if (on != n || obs_ip[i] !== exp_ip(n)) begin
                errors++;
                $display("FAIL fifo_vec%0d num=%0d ip=%h required %0d/%h", i, on, obs_ip[i], n,
                         exp_ip(n));
            end
            if (i > 0) begin
                checks++;
                if (obs_cyc[i] - prev < 2) begin
                    errors++;
                    $display("FAIL no_back_to_back gap=%0d required >=2", obs_cyc[i] - prev);
                end
            end
            prev = obs_cyc[i];
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int n, on;
        do_reset();
        sel = 0;
        load(1); load(2); load(4); load(5); load(6);
        tick();
        checks++;
        if (ovf0 !== 1'b1 || pend0 !== 16'h0036) begin
            errors++;
            $display("FAIL overflow_drop ovf=%b pend=%h required 1/0036", ovf0, pend0);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr ovf=%b required 0", ovf0);
        end
        ovf_clr = 1'b1;
        load(8);
        ovf_clr = 1'b0;
        checks++;
        if (ovf0 !== 1'b1 || pend0 !== 16'h0036) begin
            errors++;
            $display("FAIL ovf_set_wins ovf=%b pend=%h required 1/0036", ovf0, pend0);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        // Full FIFO popping and pushing in the same cycle must not overflow.
        exp_q = '{1, 2, 4, 5, 8};
        irq_ready = 1'b1;
        load(8);
        irq_ready = 1'b0;
        checks++;
        if (ovf0 !== 1'b0 || pend0 !== 16'h0134) begin
            errors++;
            $display("FAIL full_pop_push ovf=%b pend=%h required 0/0134", ovf0, pend0);
        end
        wait_obs(5, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovf_drain_timeout got=%0d required 5", obs_num.size());
        end
        while (exp_q.size() > 0) begin
            n = exp_q.pop_front();
            on = (obs_num.size() > 0) ? obs_num.pop_front() : -1;
            checks++;
            if (on != n) begin
                errors++;
                $display("FAIL ovf_order num=%0d required %0d", on, n);
            end
        end
    endtask

    task automatic test_priority();
        bit ok;
        int n, on;
        do_reset();
        sel = 1;
        load(12); load(7); load(2);
        exp_q = '{12, 2, 7};
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (v1 !== 1'b1 || n1 !== 4'd12 || ip1 !== exp_ip(12) || pend1 !== 16'h1084 ||
            ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL prio_hold v=%b num=%0d ip=%h pend=%h ovf=%b required 1/12/%h/1084/0",
                     v1, n1, ip1, pend1, ovf1, exp_ip(12));
        end
        wait_obs(3, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL prio_drain_timeout got=%0d required 3", obs_num.size());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            n = exp_q.pop_front();
            on = (obs_num.size() > 0) ? obs_num.pop_front() : -1;
            checks++;
            if (on != n || obs_ip[i] !== exp_ip(n)) begin
                errors++;
                $display("FAIL prio_vec%0d num=%0d ip=%h required %0d/%h", i, on, obs_ip[i], n,
                         exp_ip(n));
            end
        end
        sel = 0;
    endtask

    task automatic test_mask_rearm();
        bit ok;
        int on;
        do_reset();
        sel = 0;
        irq_mask = 16'h0020;
        load(5);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (v0 !== 1'b0 || pend0 !== 16'h0) begin
            errors++;
            $display("FAIL masked_load valid=%b pend=%h required 0/0000", v0, pend0);
        end
        irq_mask = '0;
        load(5);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (v0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        irq_ready = 1'b1;
        load(5);
        irq_ready = 1'b0;
        checks++;
        if (!ok || pend0 !== 16'h0020 || v0 !== 1'b0) begin
            errors++;
            $display("FAIL rearm_pending seen=%b pend=%h valid=%b required 1/0020/0", ok, pend0,
                     v0);
        end
        tick();
        checks++;
        if (v0 !== 1'b1 || n0 !== 4'd5) begin
            errors++;
            $display("FAIL rearm_second valid=%b num=%0d required 1/5", v0, n0);
        end
        wait_obs(2, ok);
        for (int i = 0; i < 2; i++) begin
            on = (obs_num.size() > 0) ? obs_num.pop_front() : -1;
            checks++;
            if (on != 5) begin
                errors++;
                $display("FAIL rearm_vec%0d num=%0d required 5", i, on);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        sel = 0;
        load(1); load(2); load(3);
        tick();
        checks++;
        if (v0 !== 1'b1 || pend0 !== 16'h000E) begin
            errors++;
            $display("FAIL pre_reset_state valid=%b pend=%h required 1/000E", v0, pend0);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({stg0, done0, v0, n0, ip0, pend0, ovf0} !== {5'h1F, 1'b0, 1'b0, 4'h0, 42'h0, 16'h0, 1'b0})
        begin
            errors++;
            $display("FAIL async_reset stg=%h done=%b v=%b num=%h ip=%h pend=%h ovf=%b",
                     stg0, done0, v0, n0, ip0, pend0, ovf0);
        end
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (v0 !== 1'b0 || pend0 !== 16'h0) begin
            errors++;
            $display("FAIL stale_after_reset valid=%b pend=%h required 0/0000", v0, pend0);
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_overflow();
        test_priority();
        test_mask_rearm();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
